// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: widths, FSM state
// encoding and the hard-wired zero register index.
package mem_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int ZERO_REG = 0;

  // IDLE: no memory transaction outstanding; ACCESS: request in flight.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Request/acknowledge sequencer for data memory. Owns the stage state,
// the upstream ready, the registered dmem_req and the retire strobe.
module mem_access_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ex_valid,
  input  logic ex_mem_acc,    // EX instruction needs a memory transaction
  input  logic m_valid,
  input  logic m_plain,       // M instruction retires without a transaction
  input  logic dmem_ack,
  output logic ex_ready,
  output logic access_start,  // a transaction is launched at this edge
  output logic access_done,   // the outstanding transaction completes now
  output logic retire,
  output logic dmem_req
);

  state_e state_q, state_d;
  logic   dmem_req_q, dmem_req_d;

  // Next-state, ready and retire decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned and infers a latch.
    state_d     = state_q;
    dmem_req_d  = dmem_req_q;
    ex_ready    = 1'b0;
    access_done = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        retire   = m_valid && m_plain;
        if (ex_valid && ex_mem_acc) begin
          state_d    = ACCESS;
          dmem_req_d = 1'b1;
        end else begin
          dmem_req_d = 1'b0;
        end
      end
      ACCESS: begin
        // Ready depends only on the ack so no combinational path runs from ex_valid.
        ex_ready = dmem_ack;
        if (dmem_ack) begin
          access_done = 1'b1;
          retire      = 1'b1;
          if (ex_valid && ex_mem_acc) begin
            state_d    = ACCESS;
            dmem_req_d = 1'b1;
          end else begin
            state_d    = IDLE;
            dmem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  assign access_start = ex_valid && ex_ready && ex_mem_acc;
  assign dmem_req     = dmem_req_q;

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      dmem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dmem_req_q <= dmem_req_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: M register, data-memory interface registers, MEM/WB
// register and the MEM/WB forwarding taps.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned loads/stores trap
// instead of accessing memory and raise misalign_err).
module mem_stage #(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_W  = mem_stage_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_r,
  input  logic              ex_mem_w,
  input  logic              ex_wb_en,
  input  logic [REG_W-1:0]  ex_reg_dest,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] fwd_mem_data,
  output logic [REG_W-1:0]  fwd_mem_dest,
  output logic              fwd_mem_en,
  output logic              wb_valid,
  output logic              wb_en_out,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  import mem_stage_pkg::*;

  // M register
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_alu_q, m_alu_d;
  logic [DATA_W-1:0] m_st_q, m_st_d;
  logic              m_r_q, m_r_d;
  logic              m_w_q, m_w_d;
  logic              m_wb_q, m_wb_d;
  logic [REG_W-1:0]  m_dest_q, m_dest_d;
  // Memory interface registers
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  // WB register
  logic              wb_valid_q, wb_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic accept, ex_mem_acc, m_plain, m_trap, m_dest_nz;
  logic access_start, access_done, retire;

`ifdef MISALIGN_TRAP_EN
  logic ex_misaligned;
  logic m_mis_q, m_mis_d;
  logic mis_err_q, mis_err_d;

  // A misaligned load/store never reaches memory; it retires as a trap.
  assign ex_misaligned = (ex_mem_r || ex_mem_w) && (ex_alu_out[1:0] != 2'b00);
  assign ex_mem_acc    = (ex_mem_r || ex_mem_w) && !ex_misaligned;
  assign m_trap        = m_mis_q;
  assign misalign_err  = mis_err_q;
`else
  assign ex_mem_acc = ex_mem_r || ex_mem_w;
  assign m_trap     = 1'b0;
`endif

  assign accept    = ex_valid && ex_ready;
  assign m_plain   = !(m_r_q || m_w_q) || m_trap;
  assign m_dest_nz = (m_dest_q != REG_W'(ZERO_REG));

  mem_access_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_acc   (ex_mem_acc),
    .m_valid      (m_valid_q),
    .m_plain      (m_plain),
    .dmem_ack     (dmem_ack),
    .ex_ready     (ex_ready),
    .access_start (access_start),
    .access_done  (access_done),
    .retire       (retire),
    .dmem_req     (dmem_req)
  );

  // Next values for the M, memory-interface and WB registers.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_alu_d      = m_alu_q;
    m_st_d       = m_st_q;
    m_r_d        = m_r_q;
    m_w_d        = m_w_q;
    m_wb_d       = m_wb_q;
    m_dest_d     = m_dest_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = retire;
    wb_en_d      = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
`ifdef MISALIGN_TRAP_EN
    m_mis_d      = m_mis_q;
    mis_err_d    = retire && m_mis_q;
`endif

    if (accept) begin
      m_valid_d = 1'b1;
      m_alu_d   = ex_alu_out;
      m_st_d    = ex_st_data;
      // Load and store both set is treated as a store.
      m_r_d     = ex_mem_r && !ex_mem_w;
      m_w_d     = ex_mem_w;
      m_wb_d    = ex_wb_en;
      m_dest_d  = ex_reg_dest;
`ifdef MISALIGN_TRAP_EN
      m_mis_d   = ex_misaligned;
`endif
    end else if (retire) begin
      m_valid_d = 1'b0;
    end

    if (access_start) begin
      dmem_we_d    = ex_mem_w;
      dmem_addr_d  = ex_alu_out;
      dmem_wdata_d = ex_st_data;
    end else if (access_done) begin
      dmem_we_d = 1'b0;
    end

    if (retire) begin
      wb_dest_d = m_dest_q;
      wb_data_d = (m_r_q && !m_trap) ? dmem_rdata : m_alu_q;
      wb_en_d   = m_wb_q && !m_w_q && m_dest_nz && !m_trap;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      // NOTE: the M payload is reset too so the forwarding taps never show X after reset.
      m_alu_q      <= '0;
      m_st_q       <= '0;
      m_r_q        <= 1'b0;
      m_w_q        <= 1'b0;
      m_wb_q       <= 1'b0;
      m_dest_q     <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      m_mis_q      <= 1'b0;
      mis_err_q    <= 1'b0;
`endif
    end else begin
      m_valid_q    <= m_valid_d;
      m_alu_q      <= m_alu_d;
      m_st_q       <= m_st_d;
      m_r_q        <= m_r_d;
      m_w_q        <= m_w_d;
      m_wb_q       <= m_wb_d;
      m_dest_q     <= m_dest_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
`ifdef MISALIGN_TRAP_EN
      m_mis_q      <= m_mis_d;
      mis_err_q    <= mis_err_d;
`endif
    end
  end

  assign stall        = !ex_ready;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  // Load results are not available in M, so only ALU results forward from here.
  assign fwd_mem_en   = m_valid_q && m_wb_q && !m_r_q && !m_w_q && m_dest_nz;
  assign fwd_mem_data = m_alu_q;
  assign fwd_mem_dest = m_dest_q;
  assign wb_valid     = wb_valid_q;
  assign wb_en_out    = wb_en_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result (used as address or as result) and the forwarded store data.
- Runs a request/acknowledge transaction with data memory for loads and stores, stalling execute while the transaction is outstanding.
- Produces MEM/WB register contents plus the MEM and WB forwarding taps that execute's operand muxes select from.

Parameters:
- DATA_W, 32, datapath and address width
- REG_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute presents an instruction this cycle
- ex_ready  out  1  stage accepts the instruction this cycle
- ex_alu_out  in  DATA_W  ALU result / memory address
- ex_st_data  in  DATA_W  store data, already forwarded
- ex_mem_r  in  1  load
- ex_mem_w  in  1  store
- ex_wb_en  in  1  writes a register
- ex_reg_dest  in  REG_W  destination register
- stall  out  1  equals !ex_ready
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  DATA_W  address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  request completed; dmem_rdata valid this cycle
- dmem_rdata  in  DATA_W  load data
- fwd_mem_data  out  DATA_W  MEM forwarding tap
- fwd_mem_dest  out  REG_W  MEM forwarding destination
- fwd_mem_en  out  1  MEM forwarding tap valid
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_en_out  out  1  register write enable
- wb_dest  out  REG_W  write-back destination
- wb_data  out  DATA_W  write-back data; WB forwarding tap

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- On reset: state IDLE; m_valid=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; wb_valid=0; wb_en_out=0; wb_dest=0; wb_data=0; fwd_mem_en=0.
- M register: m_valid, m_alu, m_st, m_r, m_w, m_wb, m_dest. Loaded when ex_valid && ex_ready.
- States:
  - IDLE:
    - ex_ready=1.
    - If m_valid and neither m_r nor m_w: instruction retires this cycle.
    - On accept of a load or store, next state is ACCESS. dmem_req is registered high; dmem_addr, dmem_we and dmem_wdata load from the EX inputs.
    - Loads and stores never retire from IDLE.
  - ACCESS:
    - dmem_req=1; address, we and wdata held stable.
    - ex_ready = dmem_ack.
    - On dmem_ack: instruction retires. Next state is ACCESS if a load or store is accepted the same cycle, otherwise IDLE.
    - dmem_req drops the next cycle unless a new access starts; back-to-back accesses keep dmem_req high with new address and data.
- ex_ready is combinational from state and dmem_ack only (no path from ex_valid).
- Retire (registered into WB at the edge):
  - wb_valid=1.
  - wb_data = dmem_rdata for a load, otherwise m_alu.
  - wb_en_out = m_wb && !m_w && (m_dest != 0).
  - wb_dest = m_dest.
  - If nothing retires: wb_valid=0 and wb_en_out=0; wb_data and wb_dest hold.
- m_valid clears on retire unless a new instruction is accepted in the same cycle.
- Latency:
  - Non-memory instruction: accepted at N, WB at N+2.
  - Load or store with ack at its first request cycle: WB at N+2.
  - Each extra wait cycle adds 1.
- fwd_mem_en = m_valid && m_wb && !m_r && !m_w && (m_dest != 0). fwd_mem_data=m_alu; fwd_mem_dest=m_dest. Load results forward only from WB.
- Boundaries:
  - dmem_ack while IDLE is ignored.
  - ex_mem_r and ex_mem_w both set: treated as a store.
  - Reset during ACCESS: dmem_req=0 at the next edge; the in-flight instruction is dropped; a late ack is ignored.
  - ex_valid=0 in any state: nothing is accepted; M register contents are retained for forwarding but m_valid clears after retire.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A load or store with address[1:0] != 0 does not enter ACCESS.
  - It retires from IDLE with wb_en_out=0.
  - Output misalign_err (1 bit, reset 0) pulses one cycle, aligned with wb_valid.
- MISALIGN_TRAP_EN undefined: no misalign_err port; addresses pass to memory unmodified.

Decomposition:
- Shared package: DATA_W, REG_W, state encoding (IDLE, ACCESS), zero-register index constant.
- One natural sub-module: mem_access_fsm. It owns the state, ex_ready, dmem_req and the retire strobe.
- Datapath and M/WB registers stay in mem_stage.

Test Plan:
- Reset, then add with alu_out=0x10, dest=3 -> fwd_mem_en=1 (data 0x10) at N+1; wb_valid=1, wb_en_out=1, wb_data=0x10, wb_dest=3 at N+2; dmem_req stays 0.
- Load, address 0x40, ack after 3 wait cycles, rdata 0xDEADBEEF -> stall=1 for 3 cycles; wb_data=0xDEADBEEF; fwd_mem_en=0 throughout.
- Store, address 0x44, data 0x1234, ack in first cycle -> dmem_we=1, dmem_wdata=0x1234 for one cycle; wb_en_out=0 despite ex_wb_en=1.
- Store then load back-to-back, ack each on first cycle -> dmem_req high two consecutive cycles with addresses 0x44 then 0x48; no bubble.
- rst pulsed in ACCESS before ack, then ack arrives -> dmem_req=0 after the edge; wb_valid stays 0.
- With MISALIGN_TRAP_EN, load at 0x42 -> no dmem_req; misalign_err=1 with wb_valid; wb_en_out=0.
